// File: rtl/grey_display.sv
`default_nettype none
// ============================================================================
//  Module      : grey_display
//  Description : Synchronises an 8-bit Gray count coming from another clock
//                domain, converts it to binary and shows the binary value on a
//                single 7-segment digit. The low nibble and the high nibble are
//                shown alternately, each for 2^DWELL_LOG2 clocks.
//
//  Parameters  : DWELL_LOG2 - log2 of the clocks each nibble stays on the
//                             display (1..16)
//
//  Ports       : clk      in   sole clock, rising edge
//                reset    in   asynchronous, active-high reset
//                grey_in  in   [7:0] Gray count, asynchronous to clk
//                bin_out  out  [7:0] registered binary equivalent of grey_in
//                seg      out  [6:0] registered segments {g,f,e,d,c,b,a},
//                              active-high
//                dp       out  registered; 1 = high nibble on display
//                err      out  registered sticky step-violation flag
//
//  Build option: GREY_DISPLAY_CHECK_EN
//                defined   - the Gray step checker is built. Two consecutive
//                            synchronised samples that differ in two or more
//                            bits set err, which stays set until reset, and
//                            the high-nibble phase then shows "E".
//                undefined - no checker logic; err is tied low and the display
//                            is never overridden.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module grey_display #(
    parameter int DWELL_LOG2 = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] grey_in,
    output logic [7:0] bin_out,
    output logic [6:0] seg,
    output logic       dp,
    output logic       err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] C_SEG_E = 7'h79;

    // ------------------------------------------------------------------------
    // Display phase state machine
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        SHOW_LO = 1'b0,
        SHOW_HI = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [7:0]            r_s1;
    logic [7:0]            r_s2;
    logic [7:0]            w_bin;
    logic [7:0]            r_bin;
    logic [DWELL_LOG2-1:0] r_dwell;
    logic                  w_dwell_tc;
    logic                  w_snap_load;
    logic [7:0]            r_snap;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_nxt;
    logic                  w_hi_override;
    logic [6:0]            r_seg;
    logic                  r_dp;

    // ------------------------------------------------------------------------
    // Hex font for one nibble, segments {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_hex_font(input logic [3:0] i_nib);
        logic [6:0] v;
        case (i_nib)
            4'h0:    v = 7'h3F;
            4'h1:    v = 7'h06;
            4'h2:    v = 7'h5B;
            4'h3:    v = 7'h4F;
            4'h4:    v = 7'h66;
            4'h5:    v = 7'h6D;
            4'h6:    v = 7'h7D;
            4'h7:    v = 7'h07;
            4'h8:    v = 7'h7F;
            4'h9:    v = 7'h6F;
            4'hA:    v = 7'h77;
            4'hB:    v = 7'h7C;
            4'hC:    v = 7'h39;
            4'hD:    v = 7'h5E;
            4'hE:    v = 7'h79;
            default: v = 7'h71;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Because the upstream counter is Gray coded, at
    // most one bit is in flight at any time, so a per-bit synchroniser yields
    // either the old or the new count, never a mix.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 8'h00;
            r_s2 <= 8'h00;
        end else begin
            r_s1 <= grey_in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Gray to binary: bit i is the XOR of all Gray bits from 7 down to i.
    // Written as a reduction per bit so there is no bit-to-bit chain inside
    // one vector.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bin
            assign w_bin[gi] = ^r_s2[7:gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin <= 8'h00;
        end else begin
            r_bin <= w_bin;
        end
    end

    assign bin_out = r_bin;

    // ------------------------------------------------------------------------
    // Dwell counter. It is exactly DWELL_LOG2 bits wide, so incrementing past
    // the terminal count wraps to zero on its own.
    // ------------------------------------------------------------------------
    assign w_dwell_tc = &r_dwell;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DWELL_LOG2'(1);
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SHOW_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state. The snapshot is taken only when leaving SHOW_HI, so a
    // low/high display pair always comes from one captured value.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_snap_load = 1'b0;
        if (w_dwell_tc) begin
            case (r_state)
                SHOW_LO: begin
                    w_state_nxt = SHOW_HI;
                end
                SHOW_HI: begin
                    w_state_nxt = SHOW_LO;
                    w_snap_load = 1'b1;
                end
                default: begin
                    w_state_nxt = SHOW_LO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Display snapshot register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= 8'h00;
        end else if (w_snap_load) begin
            r_snap <= r_bin;
        end
    end

`ifdef GREY_DISPLAY_CHECK_EN
    // ------------------------------------------------------------------------
    // Gray step checker. Consecutive synchronised samples may differ in at
    // most one bit. Two or more differing bits means the difference has a
    // second set bit, i.e. clearing its lowest set bit leaves it non-zero.
    // The violation is registered on the edge the offending sample enters
    // r_prev and folded into the sticky flag one clock later.
    // ------------------------------------------------------------------------
    logic [7:0] r_prev;
    logic       r_valid;
    logic       r_viol;
    logic       r_err;
    logic [7:0] w_diff;
    logic       w_step_bad;

    assign w_diff     = r_s2 ^ r_prev;
    assign w_step_bad = r_valid & (|(w_diff & (w_diff - 8'd1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= 8'h00;
            r_valid <= 1'b0;
            r_viol  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_prev  <= r_s2;
            r_valid <= 1'b1;
            r_viol  <= w_step_bad;
            r_err   <= r_err | r_viol;
        end
    end

    assign err           = r_err;
    assign w_hi_override = r_err;
`else
    assign err           = 1'b0;
    assign w_hi_override = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Segment decode and output registers. seg/dp reflect the state and
    // snapshot of the previous clock.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nib     = (r_state == SHOW_HI) ? r_snap[7:4] : r_snap[3:0];
        w_seg_nxt = f_hex_font(w_nib);
        if ((r_state == SHOW_HI) && w_hi_override) begin
            w_seg_nxt = C_SEG_E;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= 7'h00;
            r_dp  <= 1'b0;
        end else begin
            r_seg <= w_seg_nxt;
            r_dp  <= (r_state == SHOW_HI);
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_grey_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grey_display
//  Description : Self-checking bench for grey_display (DWELL_LOG2 = 2).
//                A reference model predicts every output after every clock
//                from the recorded input history since the last reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grey_display;

    localparam int DWELL_LOG2 = 2;
    localparam int D          = 1 << DWELL_LOG2;
    localparam int HMAX       = 4095;
`ifdef GREY_DISPLAY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [6:0] FONT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] grey_in;
    logic [7:0] bin_out;
    logic [6:0] seg;
    logic       dp;
    logic       err;

    grey_display #(.DWELL_LOG2(DWELL_LOG2)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .grey_in (grey_in),
        .bin_out (bin_out),
        .seg     (seg),
        .dp      (dp),
        .err     (err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         t     = 0;      // clocks since reset release
    int         viol_at = 0;    // first clock whose input jumped >1 bit (0 = none)
    logic [7:0] hist [0:HMAX];  // hist[k] = grey_in present just before clock k
    logic [7:0] cur;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%02h exp=%02h", tag, t, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] h_at(input int j);
        return (j < 1) ? 8'h00 : hist[j];
    endfunction

    // Binary value whose Gray code is g, found by search.
    function automatic logic [7:0] g2b(input logic [7:0] g);
        for (int b = 0; b < 256; b++) begin
            if (8'(b ^ (b >> 1)) == g) return 8'(b);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] bin_exp(input int tt);
        return g2b(h_at(tt - 2));
    endfunction

    function automatic logic [7:0] snap_exp(input int tt);
        int e;
        e = (tt / (2 * D)) * (2 * D);
        return (e == 0) ? 8'h00 : bin_exp(e - 1);
    endfunction

    function automatic bit err_exp(input int tt);
        return CHK && (viol_at > 0) && (tt >= viol_at + 3);
    endfunction

    function automatic logic [6:0] seg_exp(input int tt);
        logic [7:0] s;
        s = snap_exp(tt - 1);
        if ((((tt - 1) / D) % 2) == 0) return FONT[s[3:0]];
        if (err_exp(tt - 1)) return 7'h79;
        return FONT[s[7:4]];
    endfunction

    function automatic bit dp_exp(input int tt);
        return (((tt - 1) / D) % 2) == 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_all();
        chk("bin_out", bin_out, bin_exp(t));
        chk("seg", {1'b0, seg}, {1'b0, seg_exp(t)});
        chk("dp", {7'b0, dp}, {7'b0, dp_exp(t)});
        chk("err", {7'b0, err}, {7'b0, err_exp(t)});
    endtask

    task automatic cyc(input logic [7:0] g);
        if (t + 1 > HMAX) begin
            bad++;
            $display("FAIL hist_overflow t=%0d got=%0d exp<=%0d", t, t + 1, HMAX);
            $fatal(1, "history overflow");
        end
        grey_in     = g;
        hist[t + 1] = g;
        if ((viol_at == 0) && ($countones(g ^ h_at(t)) >= 2)) viol_at = t + 1;
        @(posedge clk);
        t++;
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_bin", bin_out, 8'h00);
        chk("rst_seg", {1'b0, seg}, 8'h00);
        chk("rst_dp", {7'b0, dp}, 8'h00);
        chk("rst_err", {7'b0, err}, 8'h00);
        @(posedge clk);
        #1;
        chk("rst_seg_hold", {1'b0, seg}, 8'h00);
        @(negedge clk);
        reset   = 1'b0;
        t       = 0;
        viol_at = 0;
    endtask

    // Change input so its new value is sampled one clock before a snapshot.
    task automatic change_before_snap(input logic [7:0] v);
        while (((t + 1) % (2 * D)) != (2 * D - 1)) cyc(grey_in);
        cyc(v);
        repeat (4 * D) cyc(v);
    endtask

    initial begin
        reset   = 1'b1;
        grey_in = 8'h00;
        cur     = 8'h00;
        do_reset();

        // Directed Gray steps 00,01,03,02, 8 clocks each.
        cyc(8'h00);
        chk("first_seg", {1'b0, seg}, 8'h3F);
        repeat (7) cyc(8'h00);
        repeat (8) cyc(8'h01);
        repeat (8) cyc(8'h03);
        repeat (8) cyc(8'h02);

        // Remaining full Gray sequence, wrap 80->00, then walk up to C7.
        for (int b = 4; b < 256 + 134; b++) begin
            cur = 8'((b % 256) ^ ((b % 256) >> 1));
            repeat ($urandom_range(1, 3)) cyc(cur);
        end
        repeat (8 * D) cyc(cur);
        chk("hold_c7_bin", bin_out, 8'h85);
        chk("seq_err_clean", {7'b0, err}, 8'h00);

        // Changes landing one clock before a snapshot.
        for (int k = 0; k < 6; k++) begin
            cur = cur ^ 8'(1 << $urandom_range(0, 7));
            change_before_snap(cur);
        end

        // Random legal walk with stalls.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 1) cur = cur ^ 8'(1 << $urandom_range(0, 7));
            cyc(cur);
        end

        // Reset mid-dwell, then resume from zero.
        repeat (3) cyc(cur);
        do_reset();
        cur = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) cur = cur ^ 8'(1 << $urandom_range(0, 7));
            cyc(cur);
        end

        // Illegal jump 00 -> 03, then keep running.
        do_reset();
        repeat (5) cyc(8'h00);
        cur = 8'h03;
        repeat (6 * D) cyc(cur);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) cur = cur ^ 8'(1 << $urandom_range(0, 7));
            cyc(cur);
        end
        chk("err_sticky", {7'b0, err}, {7'b0, CHK});

        // Reset clears the flag.
        do_reset();
        repeat (4 * D) cyc(8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
